// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_buffer
// Description : Retirement-trace capture unit for the pipelined 16-bit CPU.
//               Each cycle with a retire event (register write, memory read,
//               memory write, halt) is packed with its cycle stamp and queued
//               in a DEPTH-entry FIFO that a debug reader drains over a
//               valid/ready port. Also keeps cycle/instruction/drop
//               statistics, a cycle-limit watchdog, and freezes on halt.
// Ports       :
//   clk, rst_n                  clock, synchronous active-low reset
//   ev_regwrite/memread/
//   memwrite/halt               retire event flags for this cycle
//   ev_pc, ev_reg, ev_wdata,
//   ev_addr, ev_mdata           retire event fields
//   rd_valid / rd_ready         head-entry handshake (show-ahead)
//   rd_kind, rd_pc, rd_reg,
//   rd_wdata, rd_addr,
//   rd_mdata, rd_cycle          head entry, zero while empty
//   cycle_count, inst_count,
//   drop_count                  statistics
//   halted, timeout, overflow   sticky status
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
   parameter int DATA_W     = 16,
   parameter int REG_W      = 4,
   parameter int DEPTH      = 16,
   parameter int CYC_W      = 32,
   parameter int MAX_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ev_regwrite,
   input  logic              ev_memread,
   input  logic              ev_memwrite,
   input  logic              ev_halt,
   input  logic [DATA_W-1:0] ev_pc,
   input  logic [REG_W-1:0]  ev_reg,
   input  logic [DATA_W-1:0] ev_wdata,
   input  logic [DATA_W-1:0] ev_addr,
   input  logic [DATA_W-1:0] ev_mdata,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [3:0]        rd_kind,
   output logic [DATA_W-1:0] rd_pc,
   output logic [DATA_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_wdata,
   output logic [DATA_W-1:0] rd_mdata,
   output logic [REG_W-1:0]  rd_reg,
   output logic [CYC_W-1:0]  rd_cycle,
   output logic [CYC_W-1:0]  cycle_count,
   output logic [CYC_W-1:0]  inst_count,
   output logic [CYC_W-1:0]  drop_count,
   output logic              halted,
   output logic              timeout,
   output logic              overflow
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 4 + REG_W + 4 * DATA_W + CYC_W;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [PTR_W:0]     r_count;

   logic               w_capture;
   logic               w_event;
   logic               w_pop;
   logic               w_full;
   logic               w_push;
   logic               w_drop;
   logic               w_countsInst;
   logic               w_atLimit;
   logic [ENTRY_W-1:0] w_entry;
   logic [ENTRY_W-1:0] w_head;

   assign w_capture    = !halted && !timeout;
   assign w_event      = w_capture &&
                         (ev_regwrite || ev_memread || ev_memwrite || ev_halt);
   assign rd_valid     = (r_count != '0);
   assign w_pop        = rd_valid && rd_ready;
   assign w_full       = (r_count == (PTR_W+1)'(DEPTH));
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push       = w_event && (!w_full || w_pop);
   assign w_drop       = w_event && w_full && !w_pop;
   // Read-only cycles are not counted as retired instructions.
   assign w_countsInst = ev_halt || ev_regwrite || ev_memwrite;
   assign w_atLimit    = (cycle_count == CYC_W'(MAX_CYCLES));

   // Stamp is the pre-increment cycle count; unused fields are kept as seen.
   assign w_entry = {ev_halt, ev_memwrite, ev_memread, ev_regwrite,
                     ev_pc, ev_reg, ev_wdata, ev_addr, ev_mdata, cycle_count};

   // Show-ahead head, forced to zero while the FIFO is empty.
   assign w_head = rd_valid ? r_mem[r_rdPtr] : '0;
   assign {rd_kind, rd_pc, rd_reg, rd_wdata, rd_addr, rd_mdata, rd_cycle} = w_head;

   // Storage needs no reset: entries are only visible through the count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (PTR_W+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_count <= '0;
         inst_count  <= '0;
         drop_count  <= '0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (w_capture) begin
            // The watchdog fires instead of advancing past the limit.
            if (w_atLimit) begin
               timeout <= 1'b1;
            end else begin
               cycle_count <= cycle_count + CYC_W'(1);
            end
         end
         if (w_event && w_countsInst) begin
            inst_count <= inst_count + CYC_W'(1);
         end
         if (w_event && ev_halt) begin
            halted <= 1'b1;
         end
         if (w_drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
               drop_count <= drop_count + CYC_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_retire_trace_buffer
// Description : Self-checking bench for retire_trace_buffer. A queue-based
//               reference model tracks FIFO contents and statistics; accepted
//               entries go into a scoreboard that a negedge monitor pops on
//               every DUT handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int DEPTH  = 16;
   localparam int CYC_W  = 32;
   localparam int MAXC   = 150;

   typedef struct packed {
      logic [3:0]        kind;
      logic [DATA_W-1:0] pc;
      logic [REG_W-1:0]  rg;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] mdata;
      logic [CYC_W-1:0]  cyc;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ev_regwrite, ev_memread, ev_memwrite, ev_halt;
   logic [DATA_W-1:0] ev_pc, ev_wdata, ev_addr, ev_mdata;
   logic [REG_W-1:0]  ev_reg;
   logic              rd_valid, rd_ready;
   logic [3:0]        rd_kind;
   logic [DATA_W-1:0] rd_pc, rd_addr, rd_wdata, rd_mdata;
   logic [REG_W-1:0]  rd_reg;
   logic [CYC_W-1:0]  rd_cycle, cycle_count, inst_count, drop_count;
   logic              halted, timeout, overflow;

   always #5 clk = ~clk;

   retire_trace_buffer #(
      .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH),
      .CYC_W(CYC_W), .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ev_regwrite(ev_regwrite), .ev_memread(ev_memread),
      .ev_memwrite(ev_memwrite), .ev_halt(ev_halt),
      .ev_pc(ev_pc), .ev_reg(ev_reg), .ev_wdata(ev_wdata),
      .ev_addr(ev_addr), .ev_mdata(ev_mdata),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_kind(rd_kind),
      .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
      .rd_mdata(rd_mdata), .rd_reg(rd_reg), .rd_cycle(rd_cycle),
      .cycle_count(cycle_count), .inst_count(inst_count),
      .drop_count(drop_count), .halted(halted), .timeout(timeout),
      .overflow(overflow)
   );

   // Reference model state
   entry_t      mq[$];
   entry_t      sbq[$];
   logic [31:0] mCyc, mInst, mDrop;
   bit          mHalted, mTimeout, mOverflow;

   int nChecks = 0;
   int nFail   = 0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelStep();
      entry_t e;
      bit     cap;
      if (!rst_n) begin
         mq.delete();
         sbq.delete();
         mCyc = 0; mInst = 0; mDrop = 0;
         mHalted = 0; mTimeout = 0; mOverflow = 0;
      end else begin
         cap = !mHalted && !mTimeout;
         if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
         if (cap && (ev_regwrite || ev_memread || ev_memwrite || ev_halt)) begin
            e.kind  = {ev_halt, ev_memwrite, ev_memread, ev_regwrite};
            e.pc    = ev_pc;
            e.rg    = ev_reg;
            e.wdata = ev_wdata;
            e.addr  = ev_addr;
            e.mdata = ev_mdata;
            e.cyc   = mCyc;
            if (mq.size() < DEPTH) begin
               mq.push_back(e);
               sbq.push_back(e);
            end else begin
               if (mDrop != 32'hFFFF_FFFF) mDrop++;
               mOverflow = 1;
            end
            if (ev_halt || ev_regwrite || ev_memwrite) mInst++;
            if (ev_halt) mHalted = 1;
         end
         if (cap) begin
            if (mCyc == MAXC) mTimeout = 1;
            else mCyc++;
         end
      end
   endtask

   // One clock: the model follows the edge with the inputs that were present.
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic setEv(input bit rw, input bit mr, input bit mw, input bit h);
      ev_regwrite = rw; ev_memread = mr; ev_memwrite = mw; ev_halt = h;
      ev_pc    = DATA_W'($urandom);
      ev_reg   = REG_W'($urandom);
      ev_wdata = DATA_W'($urandom);
      ev_addr  = DATA_W'($urandom);
      ev_mdata = DATA_W'($urandom);
   endtask

   task automatic randEv(input int haltOdds);
      logic [2:0] k;
      k = 3'($urandom_range(0, 7));
      setEv(k[0], k[1], k[2], haltOdds > 0 && $urandom_range(0, haltOdds-1) == 0);
   endtask

   task automatic busyEv();
      logic [2:0] k;
      k = 3'($urandom_range(1, 7));
      setEv(k[0], k[1], k[2], 1'b0);
   endtask

   task automatic idle();
      ev_regwrite = 0; ev_memread = 0; ev_memwrite = 0; ev_halt = 0;
   endtask

   task automatic doReset();
      idle();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   // Monitor: status vs model, handshake entries vs scoreboard.
   initial begin
      entry_t exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("rd_valid", rd_valid, mq.size() != 0);
            chk("stats", {cycle_count, inst_count, drop_count, halted, timeout, overflow},
                {mCyc, mInst, mDrop, mHalted, mTimeout, mOverflow});
            if (!rd_valid)
               chk("gated_head",
                   {rd_kind, rd_pc, rd_reg, rd_wdata, rd_addr, rd_mdata, rd_cycle}, 0);
            if (rd_valid && rd_ready) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_pop", 1, 0);
               end else begin
                  exp = sbq.pop_front();
                  chk("entry",
                      {rd_kind, rd_pc, rd_reg, rd_wdata, rd_addr, rd_mdata, rd_cycle},
                      exp);
               end
            end
         end
      end
   end

   initial begin
      rd_ready = 0;
      idle();
      setEv(0, 0, 0, 0);
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;

      // Idle after reset
      repeat (5) tick();
      chk("idle_cycle", cycle_count, 5);
      chk("idle_valid", rd_valid, 0);
      chk("idle_inst", inst_count, 0);
      chk("idle_flags", {halted, timeout, overflow}, 0);

      // Single register write, stamped 5
      rd_ready = 1;
      setEv(1, 0, 0, 0);
      ev_reg = 4'd3; ev_wdata = 16'h00AB; ev_pc = 16'h0004;
      tick();
      idle();
      chk("rw_kind", rd_kind, 4'b0001);
      chk("rw_cycle", rd_cycle, 5);
      chk("rw_wdata", rd_wdata, 16'h00AB);
      chk("rw_inst", inst_count, 1);
      tick();
      chk("rw_popped", rd_valid, 0);

      // Read then write, same address
      setEv(0, 1, 0, 0); ev_addr = 16'h0010;
      tick();
      chk("rd_kind", rd_kind, 4'b0010);
      setEv(0, 0, 1, 0); ev_addr = 16'h0010;
      tick();
      chk("wr_kind", rd_kind, 4'b0100);
      idle();
      tick(); tick();
      chk("rdwr_inst", inst_count, 2);

      // Overflow: 20 events into 16 slots
      doReset();
      rd_ready = 0;
      repeat (20) begin busyEv(); tick(); end
      chk("ovf_drop", drop_count, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head", rd_cycle, 0);
      // Full with simultaneous push and pop
      rd_ready = 1;
      repeat (3) begin busyEv(); tick(); end
      chk("fullpp_drop", drop_count, 4);
      idle();
      repeat (15) tick();
      chk("drain_15", rd_valid, 1);
      tick();
      chk("drain_16", rd_valid, 0);

      // Halt at stamp 7
      doReset();
      rd_ready = 0;
      repeat (7) tick();
      setEv(0, 0, 0, 1);
      tick();
      repeat (4) begin busyEv(); tick(); end
      idle();
      chk("halt_kind", rd_kind, 4'b1000);
      chk("halt_stamp", rd_cycle, 7);
      chk("halt_cycle", cycle_count, 8);
      chk("halt_flag", halted, 1);
      chk("halt_inst", inst_count, 1);
      rd_ready = 1;
      tick(); tick();
      chk("halt_drained", rd_valid, 0);

      // Watchdog
      doReset();
      repeat (MAXC + 10) begin
         busyEv();
         rd_ready = $urandom_range(0, 1) == 1;
         tick();
      end
      idle();
      chk("wd_timeout", timeout, 1);
      chk("wd_cycle", cycle_count, MAXC);
      rd_ready = 1;
      repeat (DEPTH + 2) tick();
      chk("wd_drained", rd_valid, 0);

      // Random traffic with occasional halts
      repeat (3) begin
         doReset();
         repeat (120) begin
            randEv(60);
            rd_ready = $urandom_range(0, 3) != 0;
            tick();
         end
         idle();
         rd_ready = 1;
         repeat (DEPTH + 2) tick();
      end

      // Reset in the middle of a drain
      doReset();
      rd_ready = 0;
      repeat (6) begin busyEv(); tick(); end
      idle();
      rd_ready = 1;
      tick(); tick();
      rst_n = 0;
      tick();
      chk("rst_valid", rd_valid, 0);
      chk("rst_counts", {cycle_count, inst_count, drop_count}, 0);
      chk("rst_flags", {halted, timeout, overflow}, 0);
      rst_n = 1;
      rd_ready = 0;
      repeat (3) tick();
      chk("rst_resume", cycle_count, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
`default_nettype wire
